// File: rtl/prime_scanner.sv
// Prime scanner: on start, tests candidates 2..num_max by trial division, one divisor per clock,
// streams each prime over a valid/ready handshake and reports running counts plus a done pulse.
module prime_scanner #(
    parameter int WIDTH     = 11,
    parameter int CNT_WIDTH = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     num_max,
    input  logic                 prime_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 prime_valid,
    output logic [WIDTH-1:0]     prime,
    output logic [WIDTH-1:0]     number_checked,
    output logic [CNT_WIDTH-1:0] number_of_primes
);

    typedef enum logic [1:0] {
        IDLE,
        TEST,
        EMIT,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_maxQ;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_div;

    logic [2*WIDTH-1:0] w_square;
    logic [WIDTH-1:0]   w_rem;
    logic               w_isPrime;
    logic               w_divides;
    logic               w_lastCand;

    // Full-width product so the square-root bound never wraps for large candidates.
    assign w_square   = {{WIDTH{1'b0}}, r_div} * {{WIDTH{1'b0}}, r_div};
    assign w_isPrime  = w_square > {{WIDTH{1'b0}}, r_cand};
    assign w_rem      = (r_div == '0) ? '0 : (r_cand % r_div);
    assign w_divides  = (w_rem == '0);
    assign w_lastCand = (r_cand == r_maxQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_maxQ           <= '0;
            r_cand           <= '0;
            r_div            <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            prime_valid      <= 1'b0;
            prime            <= '0;
            number_checked   <= '0;
            number_of_primes <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_maxQ           <= num_max;
                        number_checked   <= '0;
                        number_of_primes <= '0;
                        if (num_max < WIDTH'(2)) begin
                            r_state <= DONE;
                            done    <= 1'b1;
                        end else begin
                            r_cand  <= WIDTH'(2);
                            r_div   <= WIDTH'(2);
                            busy    <= 1'b1;
                            r_state <= TEST;
                        end
                    end
                end
                TEST: begin
                    if (w_isPrime) begin
                        number_of_primes <= number_of_primes + CNT_WIDTH'(1);
                        prime            <= r_cand;
                        prime_valid      <= 1'b1;
                        r_state          <= EMIT;
                    end else if (w_divides) begin
                        number_checked <= r_cand;
                        if (w_lastCand) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_cand <= r_cand + WIDTH'(1);
                            r_div  <= WIDTH'(2);
                        end
                    end else begin
                        r_div <= r_div + WIDTH'(1);
                    end
                end
                EMIT: begin
                    // Checking the last candidate before incrementing keeps num_max = all-ones from wrapping.
                    if (prime_ready) begin
                        prime_valid    <= 1'b0;
                        number_checked <= r_cand;
                        if (w_lastCand) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_cand  <= r_cand + WIDTH'(1);
                            r_div   <= WIDTH'(2);
                            r_state <= TEST;
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prime_scanner.sv
// Scoreboard bench for prime_scanner: a sieve reference queues expected primes per scan and a
// negedge monitor checks every handshake, stall hold and done report against it.
module tb_prime_scanner;

    localparam int WIDTH     = 11;
    localparam int CNT_WIDTH = WIDTH;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [WIDTH-1:0]     num_max;
    logic                 prime_ready;
    logic                 busy;
    logic                 done;
    logic                 prime_valid;
    logic [WIDTH-1:0]     prime;
    logic [WIDTH-1:0]     number_checked;
    logic [CNT_WIDTH-1:0] number_of_primes;

    int total = 0;
    int bad   = 0;

    int expQ[$];
    int expCount   = 0;
    int expChecked = 0;
    int doneCount  = 0;
    int acceptedCount = 0;
    bit randReady  = 0;

    bit prevStall = 0;
    int prevPrime = 0;
    int prevCount = 0;
    int prevChecked = 0;

    prime_scanner #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .num_max          (num_max),
        .prime_ready      (prime_ready),
        .busy             (busy),
        .done             (done),
        .prime_valid      (prime_valid),
        .prime            (prime),
        .number_checked   (number_checked),
        .number_of_primes (number_of_primes)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Sieve of Eratosthenes gives the expected prime list for a scan up to n.
    task automatic applyStimulus(input int n);
        bit composite[0:2047];
        @(posedge clk);
        #2;
        for (int i = 0; i <= 2047; i++) composite[i] = 0;
        for (int i = 2; i * i <= n; i++)
            if (!composite[i])
                for (int j = i * i; j <= n; j += i) composite[j] = 1;
        expCount = 0;
        for (int i = 2; i <= n; i++)
            if (!composite[i]) begin
                expQ.push_back(i);
                expCount++;
            end
        expChecked = (n < 2) ? 0 : n;
        num_max = WIDTH'(n);
        start   = 1;
        @(posedge clk);
        #2;
        start = 0;
    endtask

    task automatic waitDone(input int budget);
        int cycles = 0;
        while (!done && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (!done) checkOutput("doneTimeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic waitPrime(input int value, input int budget);
        int cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!(prime_valid && int'(prime) == value) && cycles < budget);
        checkOutput("primeSeen", int'(prime), value);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (randReady) prime_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prevStall = 0;
            end else begin
                if (prevStall) begin
                    checkOutput("stallValid", int'(prime_valid), 1);
                    checkOutput("stallPrime", int'(prime), prevPrime);
                    checkOutput("stallCount", int'(number_of_primes), prevCount);
                    checkOutput("stallChecked", int'(number_checked), prevChecked);
                end
                if (prime_valid && prime_ready) begin
                    checkOutput("primeExpected", int'(expQ.size() > 0), 1);
                    if (expQ.size() > 0) checkOutput("primeValue", int'(prime), expQ.pop_front());
                    acceptedCount++;
                end
                if (done) begin
                    doneCount++;
                    checkOutput("doneCount", int'(number_of_primes), expCount);
                    checkOutput("doneChecked", int'(number_checked), expChecked);
                    checkOutput("doneQueueEmpty", expQ.size(), 0);
                    checkOutput("doneBusy", int'(busy), 0);
                end
                prevStall   = prime_valid && !prime_ready;
                prevPrime   = int'(prime);
                prevCount   = int'(number_of_primes);
                prevChecked = int'(number_checked);
            end
        end
    end

    initial begin
        int base;
        int n;
        rst = 1;
        start = 0;
        num_max = '0;
        prime_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetBusy", int'(busy), 0);
        checkOutput("resetDone", int'(done), 0);
        checkOutput("resetValid", int'(prime_valid), 0);
        checkOutput("resetPrime", int'(prime), 0);
        checkOutput("resetChecked", int'(number_checked), 0);
        checkOutput("resetCount", int'(number_of_primes), 0);
        #2 rst = 0;

        $display("[TB] scan to 35, always ready");
        base = doneCount;
        applyStimulus(35);
        @(negedge clk);
        checkOutput("busyDuringScan", int'(busy), 1);
        waitDone(5000);
        checkOutput("busyAfter", int'(busy), 0);
        checkOutput("donePulseWidth", int'(done), 0);
        checkOutput("oneDone35", doneCount - base, 1);

        $display("[TB] num_max 0 and 1");
        for (int k = 0; k < 2; k++) begin
            base = doneCount;
            applyStimulus(k);
            @(negedge clk);
            checkOutput("tinyDoneLatency", int'(done), 1);
            checkOutput("tinyValid", int'(prime_valid), 0);
            @(negedge clk);
            checkOutput("tinyDoneGone", int'(done), 0);
            checkOutput("tinyOneDone", doneCount - base, 1);
        end

        $display("[TB] stall on prime 3");
        prime_ready = 0;
        applyStimulus(10);
        waitPrime(2, 200);
        @(posedge clk);
        #2 prime_ready = 1;
        @(posedge clk);
        #2 prime_ready = 0;
        waitPrime(3, 200);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("stall3Prime", int'(prime), 3);
            checkOutput("stall3Count", int'(number_of_primes), 2);
        end
        @(posedge clk);
        #2 prime_ready = 1;
        waitDone(2000);

        $display("[TB] reset after third prime");
        base = doneCount;
        n = acceptedCount;
        applyStimulus(100);
        for (int k = 0; k < 500 && acceptedCount < n + 3; k++) @(negedge clk);
        checkOutput("thirdPrimeSeen", acceptedCount - n, 3);
        @(posedge clk);
        #2 rst = 1;
        @(posedge clk);
        #2 rst = 0;
        expQ.delete();
        @(negedge clk);
        checkOutput("abortBusy", int'(busy), 0);
        checkOutput("abortValid", int'(prime_valid), 0);
        checkOutput("abortPrime", int'(prime), 0);
        checkOutput("abortCount", int'(number_of_primes), 0);
        checkOutput("abortChecked", int'(number_checked), 0);
        repeat (20) @(negedge clk);
        checkOutput("abortNoDone", doneCount - base, 0);
        applyStimulus(20);
        waitDone(5000);

        $display("[TB] start ignored mid-scan");
        base = doneCount;
        applyStimulus(30);
        repeat (20) @(posedge clk);
        #2;
        start = 1;
        num_max = WIDTH'(5);
        @(posedge clk);
        #2 start = 0;
        waitDone(5000);
        repeat (10) @(negedge clk);
        checkOutput("ignoredStartOneDone", doneCount - base, 1);

        $display("[TB] random scans with random ready");
        randReady = 1;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(int'($urandom_range(0, 300)));
            waitDone(20000);
        end
        randReady = 0;
        #1 prime_ready = 1;

        $display("[TB] full range scan");
        applyStimulus(2047);
        waitDone(60000);
        checkOutput("fullCount", int'(number_of_primes), 309);
        checkOutput("fullLastPrime", int'(prime), 2039);
        checkOutput("fullChecked", int'(number_checked), 2047);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
